// File: rtl/decode_issue_stage.sv
// Decode/issue stage: operand qualification, PIPE_DEPTH-entry writer scoreboard,
// forwarding selects, load-use stall with saturating counter, redirect squash.
module decode_issue_stage #(
    parameter int XLEN           = 32,
    parameter int REGISTER_SIZE  = 5,
    parameter int PIPE_DEPTH     = 2,
    parameter int LOAD_STAGE     = 2,
    parameter int STALL_CNT_SIZE = 16,
    parameter int FWD_SEL_SIZE   = $clog2(PIPE_DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      f_valid,
    input  logic [XLEN-1:0]           f_instruction,
    input  logic [XLEN-1:0]           f_pc,
    output logic                      f_ready,
    input  logic                      redirect,
    output logic [REGISTER_SIZE-1:0]  rf_read_addr1,
    output logic [REGISTER_SIZE-1:0]  rf_read_addr2,
    output logic                      d_valid,
    output logic [XLEN-1:0]           d_instruction,
    output logic [XLEN-1:0]           d_pc,
    output logic [REGISTER_SIZE-1:0]  d_rs1,
    output logic [REGISTER_SIZE-1:0]  d_rs2,
    output logic [REGISTER_SIZE-1:0]  d_rd,
    output logic                      d_rd_write,
    output logic                      d_is_load,
    output logic                      d_is_store,
    output logic [FWD_SEL_SIZE-1:0]   d_fwd_sel_a,
    output logic [FWD_SEL_SIZE-1:0]   d_fwd_sel_b,
    output logic [STALL_CNT_SIZE-1:0] stall_count
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    logic [6:0]               opcode;
    logic                     uses_rd, uses_rs1, uses_rs2, dec_load, dec_store;
    logic [REGISTER_SIZE-1:0] src1, src2, dst;
    logic                     dst_write;

    // Entry 1 is the issue register itself; d_valid/d_rd/... are views of it.
    logic                     sb_valid [1:PIPE_DEPTH];
    logic [REGISTER_SIZE-1:0] sb_rd    [1:PIPE_DEPTH];
    logic                     sb_wr    [1:PIPE_DEPTH];
    logic                     sb_ld    [1:PIPE_DEPTH];

    logic [FWD_SEL_SIZE-1:0]  sel_a, sel_b;
    logic                     haz_a, haz_b;
    logic                     stall, issue;

    assign opcode = f_instruction[6:0];

    always_comb begin
        uses_rd   = 1'b0;
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        dec_load  = 1'b0;
        dec_store = 1'b0;
        case (opcode)
            OPC_OP:     begin uses_rd = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            OPC_OP_IMM: begin uses_rd = 1'b1; uses_rs1 = 1'b1; end
            OPC_LOAD:   begin uses_rd = 1'b1; uses_rs1 = 1'b1; dec_load = 1'b1; end
            OPC_STORE:  begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; dec_store = 1'b1; end
            OPC_BRANCH: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            OPC_LUI:    uses_rd = 1'b1;
            OPC_AUIPC:  uses_rd = 1'b1;
            OPC_JAL:    uses_rd = 1'b1;
            OPC_JALR:   begin uses_rd = 1'b1; uses_rs1 = 1'b1; end
            default:    ;
        endcase
    end

    assign src1      = uses_rs1 ? f_instruction[15 +: REGISTER_SIZE] : '0;
    assign src2      = uses_rs2 ? f_instruction[20 +: REGISTER_SIZE] : '0;
    assign dst       = uses_rd  ? f_instruction[7 +: REGISTER_SIZE]  : '0;
    assign dst_write = uses_rd && (dst != '0);

    assign rf_read_addr1 = src1;
    assign rf_read_addr2 = src2;

    // Scan oldest to youngest so the lowest matching index (youngest writer) wins.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        haz_a = 1'b0;
        haz_b = 1'b0;
        for (int k = PIPE_DEPTH; k >= 1; k--) begin
            if (src1 != '0 && sb_valid[k] && sb_wr[k] && sb_rd[k] == src1) begin
                sel_a = FWD_SEL_SIZE'(k);
                haz_a = sb_ld[k] && (k < LOAD_STAGE);
            end
            if (src2 != '0 && sb_valid[k] && sb_wr[k] && sb_rd[k] == src2) begin
                sel_b = FWD_SEL_SIZE'(k);
                haz_b = sb_ld[k] && (k < LOAD_STAGE);
            end
        end
    end

    assign stall   = f_valid && (haz_a || haz_b) && !redirect;
    assign issue   = f_valid && !stall && !redirect;
    assign f_ready = !stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 1; k <= PIPE_DEPTH; k++) begin
                sb_valid[k] <= 1'b0;
                sb_rd[k]    <= '0;
                sb_wr[k]    <= 1'b0;
                sb_ld[k]    <= 1'b0;
            end
            d_instruction <= '0;
            d_pc          <= '0;
            d_rs1         <= '0;
            d_rs2         <= '0;
            d_is_store    <= 1'b0;
            d_fwd_sel_a   <= '0;
            d_fwd_sel_b   <= '0;
            stall_count   <= '0;
        end else begin
            for (int k = PIPE_DEPTH; k >= 2; k--) begin
                sb_valid[k] <= sb_valid[k-1];
                sb_rd[k]    <= sb_rd[k-1];
                sb_wr[k]    <= sb_wr[k-1];
                sb_ld[k]    <= sb_ld[k-1];
            end
            if (issue) begin
                sb_valid[1]   <= 1'b1;
                sb_rd[1]      <= dst;
                sb_wr[1]      <= dst_write;
                sb_ld[1]      <= dec_load;
                d_instruction <= f_instruction;
                d_pc          <= f_pc;
                d_rs1         <= src1;
                d_rs2         <= src2;
                d_is_store    <= dec_store;
                d_fwd_sel_a   <= sel_a;
                d_fwd_sel_b   <= sel_b;
            end else begin
                sb_valid[1]   <= 1'b0;
                sb_rd[1]      <= '0;
                sb_wr[1]      <= 1'b0;
                sb_ld[1]      <= 1'b0;
                d_instruction <= '0;
                d_pc          <= '0;
                d_rs1         <= '0;
                d_rs2         <= '0;
                d_is_store    <= 1'b0;
                d_fwd_sel_a   <= '0;
                d_fwd_sel_b   <= '0;
            end
            if (stall && stall_count != '1)
                stall_count <= stall_count + STALL_CNT_SIZE'(1);
        end
    end

    assign d_valid    = sb_valid[1];
    assign d_rd       = sb_rd[1];
    assign d_rd_write = sb_wr[1];
    assign d_is_load  = sb_ld[1];

endmodule

// File: tb/tb_decode_issue_stage.sv
// Bench for decode_issue_stage: table of instruction vectors with expected issue
// bundles queued at drive time and compared when d_valid appears.
module tb_decode_issue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_valid;
    logic [31:0] f_instruction;
    logic [31:0] f_pc;
    logic        redirect;

    logic        f_ready, d_valid, d_rd_write, d_is_load, d_is_store;
    logic [4:0]  rf_read_addr1, rf_read_addr2, d_rs1, d_rs2, d_rd;
    logic [31:0] d_instruction, d_pc;
    logic [1:0]  d_fwd_sel_a, d_fwd_sel_b;
    logic [15:0] stall_count;

    logic        f_ready2, d_valid2, d_rd_write2, d_is_load2, d_is_store2;
    logic [4:0]  rf_read_addr1_2, rf_read_addr2_2, d_rs1_2, d_rs2_2, d_rd_2;
    logic [31:0] d_instruction2, d_pc2;
    logic [1:0]  d_fwd_sel_a2, d_fwd_sel_b2;
    logic [1:0]  stall_count2;

    decode_issue_stage dut (
        .clk(clk), .rst(rst), .f_valid(f_valid), .f_instruction(f_instruction),
        .f_pc(f_pc), .f_ready(f_ready), .redirect(redirect),
        .rf_read_addr1(rf_read_addr1), .rf_read_addr2(rf_read_addr2),
        .d_valid(d_valid), .d_instruction(d_instruction), .d_pc(d_pc),
        .d_rs1(d_rs1), .d_rs2(d_rs2), .d_rd(d_rd), .d_rd_write(d_rd_write),
        .d_is_load(d_is_load), .d_is_store(d_is_store),
        .d_fwd_sel_a(d_fwd_sel_a), .d_fwd_sel_b(d_fwd_sel_b),
        .stall_count(stall_count)
    );

    decode_issue_stage #(.STALL_CNT_SIZE(2)) dut_sat (
        .clk(clk), .rst(rst), .f_valid(f_valid), .f_instruction(f_instruction),
        .f_pc(f_pc), .f_ready(f_ready2), .redirect(redirect),
        .rf_read_addr1(rf_read_addr1_2), .rf_read_addr2(rf_read_addr2_2),
        .d_valid(d_valid2), .d_instruction(d_instruction2), .d_pc(d_pc2),
        .d_rs1(d_rs1_2), .d_rs2(d_rs2_2), .d_rd(d_rd_2), .d_rd_write(d_rd_write2),
        .d_is_load(d_is_load2), .d_is_store(d_is_store2),
        .d_fwd_sel_a(d_fwd_sel_a2), .d_fwd_sel_b(d_fwd_sel_b2),
        .stall_count(stall_count2)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rdw;
        logic        ld;
        logic        st;
        logic [1:0]  sa;
        logic [1:0]  sb;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        int gap, stalls, rs1, rs2, rd, rdw, ld, st, sa, sb;
    } vec_t;

    localparam logic [31:0] I_ADD  = 32'h002082B3; // add x5,x1,x2
    localparam logic [31:0] I_SUB  = 32'h40328333; // sub x6,x5,x3
    localparam logic [31:0] I_ADDI = 32'h00100493; // addi x9,x0,1
    localparam logic [31:0] I_LW   = 32'h0000A283; // lw x5,0(x1)
    localparam logic [31:0] I_USE  = 32'h00028333; // add x6,x5,x0

    exp_t        exp_q[$];
    vec_t        tbl[17];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] pc = 32'h0000_1000;
    int          exp_stall = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        exp_t act, e;
        #1;
        if (!rst && d_valid) begin
            act = {d_instruction, d_pc, d_rs1, d_rs2, d_rd, d_rd_write, d_is_load,
                   d_is_store, d_fwd_sel_a, d_fwd_sel_b};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL issue_unexpected actual=%h expected=none", act);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    errors++;
                    $display("FAIL issue_bundle actual=%h expected=%h", act, e);
                end
            end
        end
    end

    task automatic present(input vec_t v);
        exp_t e;
        int   stalls;
        repeat (v.gap) begin
            @(negedge clk);
            f_valid = 1'b0;
        end
        @(negedge clk);
        f_valid       = 1'b1;
        f_instruction = v.instr;
        f_pc          = pc;
        e = '{instr: v.instr, pc: pc, rs1: 5'(v.rs1), rs2: 5'(v.rs2), rd: 5'(v.rd),
              rdw: 1'(v.rdw), ld: 1'(v.ld), st: 1'(v.st), sa: 2'(v.sa), sb: 2'(v.sb)};
        exp_q.push_back(e);
        pc += 32'd4;
        #1;
        check("rf_read_addr", {54'd0, rf_read_addr1, rf_read_addr2},
              {54'd0, 5'(v.rs1), 5'(v.rs2)});
        stalls = 0;
        while (!f_ready && stalls < 8) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        check("stall_cycles", 64'(stalls), 64'(v.stalls));
        exp_stall += v.stalls;
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            f_valid = 1'b0;
        end
    endtask

    initial begin
        vec_t v;
        //           instr         gap st rs1 rs2 rd w ld st sa sb
        tbl[0]  = '{I_ADD,          3, 0, 1, 2, 5, 1, 0, 0, 0, 0};
        tbl[1]  = '{I_SUB,          0, 0, 5, 3, 6, 1, 0, 0, 1, 0};
        tbl[2]  = '{I_ADD,          3, 0, 1, 2, 5, 1, 0, 0, 0, 0};
        tbl[3]  = '{I_ADDI,         0, 0, 0, 0, 9, 1, 0, 0, 0, 0};
        tbl[4]  = '{I_SUB,          0, 0, 5, 3, 6, 1, 0, 0, 2, 0};
        tbl[5]  = '{I_LW,           3, 0, 1, 0, 5, 1, 1, 0, 0, 0};
        tbl[6]  = '{I_USE,          0, 1, 5, 0, 6, 1, 0, 0, 2, 0};
        tbl[7]  = '{32'h00100013,   3, 0, 0, 0, 0, 0, 0, 0, 0, 0}; // addi x0,x0,1
        tbl[8]  = '{32'h000003B3,   0, 0, 0, 0, 7, 1, 0, 0, 0, 0}; // add x7,x0,x0
        tbl[9]  = '{32'h12345437,   3, 0, 0, 0, 8, 1, 0, 0, 0, 0}; // lui x8
        tbl[10] = '{32'h0020A223,   0, 0, 1, 2, 0, 0, 0, 1, 0, 0}; // sw x2,4(x1)
        tbl[11] = '{32'h00830063,   0, 0, 6, 8, 0, 0, 0, 0, 0, 2}; // beq x6,x8
        tbl[12] = '{32'h008000EF,   3, 0, 0, 0, 1, 1, 0, 0, 0, 0}; // jal x1,8
        tbl[13] = '{32'h00008067,   0, 0, 1, 0, 0, 0, 0, 0, 1, 0}; // jalr x0,0(x1)
        tbl[14] = '{I_LW,           3, 0, 1, 0, 5, 1, 1, 0, 0, 0};
        tbl[15] = '{I_ADDI,         0, 0, 0, 0, 9, 1, 0, 0, 0, 0};
        tbl[16] = '{I_USE,          0, 0, 5, 0, 6, 1, 0, 0, 2, 0};

        rst           = 1'b1;
        f_valid       = 1'b0;
        f_instruction = I_ADD;
        f_pc          = '0;
        redirect      = 1'b0;
        #1;
        check("reset_f_ready", 64'(f_ready), 64'd1);
        check("reset_rf_addr", {54'd0, rf_read_addr1, rf_read_addr2}, {54'd0, 5'd1, 5'd2});
        check("reset_d_valid", 64'(d_valid), 64'd0);
        check("reset_stall_count", 64'(stall_count), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) present(tbl[i]);
        idle(3);
        check("stall_count_table", 64'(stall_count), 64'(exp_stall));

        // Redirect beats a load-use stall: nothing issues, nothing counted.
        v = '{I_LW, 0, 0, 1, 0, 5, 1, 1, 0, 0, 0};
        present(v);
        @(negedge clk);
        f_valid       = 1'b1;
        f_instruction = I_USE;
        redirect      = 1'b1;
        #1;
        check("redirect_f_ready", 64'(f_ready), 64'd1);
        @(posedge clk);
        #2;
        check("redirect_d_valid", 64'(d_valid), 64'd0);
        check("redirect_stall_count", 64'(stall_count), 64'(exp_stall));
        @(negedge clk);
        redirect = 1'b0;
        f_valid  = 1'b0;
        idle(3);

        // Five load-use pairs: the 2-bit counter saturates at 3.
        for (int i = 0; i < 5; i++) begin
            v = '{I_LW, 2, 0, 1, 0, 5, 1, 1, 0, 0, 0};
            present(v);
            v = '{I_USE, 0, 1, 5, 0, 6, 1, 0, 0, 2, 0};
            present(v);
        end
        idle(2);
        check("stall_count_sat", 64'(stall_count2), 64'd3);
        check("stall_count_wide", 64'(stall_count), 64'(exp_stall));

        // Asynchronous reset mid-cycle while an instruction is live.
        v = '{I_ADD, 0, 0, 1, 2, 5, 1, 0, 0, 0, 0};
        present(v);
        @(negedge clk);
        f_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_d_valid", 64'(d_valid), 64'd0);
        check("async_rst_d_instr", 64'(d_instruction), 64'd0);
        check("async_rst_rd_write", 64'(d_rd_write), 64'd0);
        check("async_rst_stall_count", 64'(stall_count), 64'd0);
        check("async_rst_f_ready", 64'(f_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
